// File: rtl/lsm_engine.sv
// Load/store-multiple sequencer: walks the register mask lowest-bit-first, one memory
// transfer per mem_ack. Optional register writeback of the final address under LSM_WRITEBACK_EN.
module lsm_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREG   = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NREG-1:0]   reg_mask,
`ifdef LSM_WRITEBACK_EN
    input  logic [REG_AW-1:0] wb_reg,
`endif
    output logic              busy,
    output logic              done,
    output logic [REG_AW:0]   count,
    output logic [REG_AW-1:0] rf_radd,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_wen,
    output logic [REG_AW-1:0] rf_wadd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        dbg_state
);

    // Memory handshake: a request (mem_ren or mem_wen with mem_addr/mem_wdata) is held
    // stable from the cycle it appears until the cycle mem_ack=1; that cycle completes it.
`ifdef LSM_WRITEBACK_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_DONE = 2'd2, S_WB = 2'd3} state_t;
    localparam state_t END_STATE = S_WB;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_DONE = 2'd2} state_t;
    localparam state_t END_STATE = S_DONE;
`endif

    state_t              r_state;
    state_t              w_next;
    logic [NREG-1:0]     r_rem_mask;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic                r_is_store;
    logic [REG_AW:0]     r_count;
    logic [REG_AW-1:0]   w_idx;
    logic [NREG-1:0]     w_clr_mask;
    logic                w_ack;
`ifdef LSM_WRITEBACK_EN
    logic [REG_AW-1:0]   r_wb_reg;
`endif

    // Scan from the top so the last assignment leaves the lowest set bit.
    always_comb begin
        w_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (r_rem_mask[i]) w_idx = REG_AW'(i);
        end
    end

    assign w_clr_mask = r_rem_mask & ~({{(NREG-1){1'b0}}, 1'b1} << w_idx);
    assign w_ack      = (r_state == S_XFER) && mem_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (reg_mask != '0) ? S_XFER : END_STATE;
            S_XFER:  if (mem_ack && (w_clr_mask == '0)) w_next = END_STATE;
`ifdef LSM_WRITEBACK_EN
            S_WB:    w_next = S_DONE;
`endif
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem_mask <= '0;
            r_cur_addr <= '0;
            r_is_store <= 1'b0;
            r_count    <= '0;
`ifdef LSM_WRITEBACK_EN
            r_wb_reg   <= '0;
`endif
        end else if ((r_state == S_IDLE) && start) begin
            r_rem_mask <= reg_mask;
            r_cur_addr <= base_addr;
            r_is_store <= is_store;
            r_count    <= '0;
`ifdef LSM_WRITEBACK_EN
            r_wb_reg   <= wb_reg;
`endif
        end else if (w_ack) begin
            r_rem_mask <= w_clr_mask;
            r_cur_addr <= r_cur_addr + ADDR_W'(1);
            r_count    <= r_count + (REG_AW+1)'(1);
        end
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        rf_radd   = '0;
        rf_wen    = 1'b0;
        rf_wadd   = '0;
        rf_wdata  = '0;
        mem_addr  = '0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        if (r_state == S_XFER) begin
            mem_addr = r_cur_addr;
            if (r_is_store) begin
                rf_radd   = w_idx;
                mem_wdata = rf_rdata;
                mem_wen   = 1'b1;
            end else begin
                mem_ren = 1'b1;
                if (mem_ack) begin
                    rf_wen   = 1'b1;
                    rf_wadd  = w_idx;
                    rf_wdata = mem_rdata;
                end
            end
        end
`ifdef LSM_WRITEBACK_EN
        // Runs after the last load write, so this value wins over a load of the same register.
        if (r_state == S_WB) begin
            rf_wen   = 1'b1;
            rf_wadd  = r_wb_reg;
            rf_wdata = DATA_W'(r_cur_addr);
        end
`endif
    end

    assign count     = r_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_lsm_engine.sv
// Bench for lsm_engine: register-file and memory models with a programmable ack delay,
// a transfer-level reference model and per-scenario checks.
module tb_lsm_engine;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int NR = 8;
    localparam int RW = 3;
    localparam int EW = RW + AW + DW;
    localparam int WW = RW + DW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          is_store = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [NR-1:0] reg_mask = '0;
    logic [RW-1:0] wb_reg = '0;
    logic          busy, done, rf_wen, mem_ren, mem_wen;
    logic [RW:0]   count;
    logic [RW-1:0] rf_radd, rf_wadd;
    logic [DW-1:0] rf_rdata, rf_wdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [1:0]    dbg_state;

    lsm_engine #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR), .REG_AW(RW)) dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store),
        .base_addr(base_addr), .reg_mask(reg_mask),
`ifdef LSM_WRITEBACK_EN
        .wb_reg(wb_reg),
`endif
        .busy(busy), .done(done), .count(count),
        .rf_radd(rf_radd), .rf_rdata(rf_rdata), .rf_wen(rf_wen), .rf_wadd(rf_wadd),
        .rf_wdata(rf_wdata), .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- environment models ----------------
    logic [DW-1:0] tb_rf [NR];
    logic [DW-1:0] tb_mem [logic [AW-1:0]];
    assign rf_rdata = tb_rf[rf_radd];

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];
    logic [WW-1:0] exp_wb_q[$];
    logic [WW-1:0] wb_q[$];
    logic [DW-1:0] exp_rf [NR];
    int            exp_cnt, exp_lat;

    int   n_tests = 0;
    int   n_fail = 0;
    int   ack_delay = 0;
    int   wait_cnt = 0;
    int   req_cycles = 0;
    int   stab_err = 0;
    int   dir_err = 0;
    bit   cur_store = 1'b0;
    bit   have_prev = 1'b0;
    logic [AW+DW+1:0] prev_req;

    // Memory responder: acks each request after ack_delay waiting cycles.
    always @(negedge clk) begin
        if (!reset) begin
            mem_ack   = 1'b0;
            wait_cnt  = 0;
            have_prev = 1'b0;
        end else if (mem_ren || mem_wen) begin
            req_cycles++;
            if ((mem_wen && !cur_store) || (mem_ren && cur_store) || (mem_ren && mem_wen)) dir_err++;
            if (have_prev && ({mem_addr, mem_ren, mem_wen, mem_wdata} !== prev_req)) stab_err++;
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                wait_cnt  = 0;
                have_prev = 1'b0;
                if (mem_wen) begin
                    tb_mem[mem_addr] = mem_wdata;
                    obs_q.push_back({rf_radd, mem_addr, mem_wdata});
                end else begin
                    mem_rdata = tb_mem.exists(mem_addr) ? tb_mem[mem_addr] : 16'hDEAD;
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = DW'($urandom);
                wait_cnt++;
                have_prev = 1'b1;
                prev_req  = {mem_addr, mem_ren, mem_wen, mem_wdata};
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = DW'($urandom);
            have_prev = 1'b0;
        end
        #1;
        if (reset && rf_wen) begin
            if (mem_ack) obs_q.push_back({rf_wadd, mem_addr, rf_wdata});
            else         wb_q.push_back({rf_wadd, rf_wdata});
            tb_rf[rf_wadd] = rf_wdata;
        end
    end

    function automatic int q_diff();
        int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic int wb_diff();
        if (wb_q.size() != exp_wb_q.size()) return 99;
        for (int i = 0; i < wb_q.size(); i++) if (wb_q[i] !== exp_wb_q[i]) return i;
        return -1;
    endfunction

    function automatic int rf_diff();
        for (int i = 0; i < NR; i++) if (tb_rf[i] !== exp_rf[i]) return i;
        return -1;
    endfunction

    // ---------------- reference model + driver ----------------
    // Expected transfers: set bits ascending, consecutive addresses mod 2^16,
    // each taking (dly+1) cycles; writeback adds one entry and one cycle.
    task automatic drive_op(input bit st, input logic [7:0] mask, input logic [AW-1:0] base,
                            input int dly, input logic [RW-1:0] wbr, input bit pulse_busy,
                            output int lat, output int busy_err, output logic [RW+2:0] post);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        obs_q.delete(); wb_q.delete(); exp_q.delete(); exp_wb_q.delete();
        req_cycles = 0; stab_err = 0; dir_err = 0;
        cur_store = st; ack_delay = dly;
        a = base; exp_cnt = 0;
        for (int i = 0; i < NR; i++) exp_rf[i] = tb_rf[i];
        for (int i = 0; i < NR; i++) begin
            if (mask[i]) begin
                d = st ? tb_rf[i] : DW'($urandom);
                if (!st) begin
                    tb_mem[a] = d;
                    exp_rf[i] = d;
                end
                exp_q.push_back({RW'(i), a, d});
                a = a + 16'd1;
                exp_cnt++;
            end
        end
        exp_lat = exp_cnt * (dly + 1);
`ifdef LSM_WRITEBACK_EN
        exp_lat++;
        exp_wb_q.push_back({wbr, a});
        exp_rf[wbr] = a;
`endif
        @(negedge clk);
        start = 1'b1; is_store = st; base_addr = base; reg_mask = mask; wb_reg = wbr;
        @(negedge clk);
        start = 1'b0; is_store = 1'($urandom); base_addr = AW'($urandom);
        reg_mask = NR'($urandom); wb_reg = RW'($urandom);
        lat = 0; busy_err = 0;
        while (!done && lat < 500) begin
            if (!busy) busy_err++;
            start = pulse_busy && (lat == 1);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        @(negedge clk);
        post = {done, busy, count};
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_tests++;
        if ({busy, done, rf_wen, mem_ren, mem_wen, count, rf_radd, rf_wadd, rf_wdata, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b rf_wen=%b ren=%b wen=%b count=%0d addr=%h, want all 0",
                     busy, done, rf_wen, mem_ren, mem_wen, count, mem_addr);
        end
    endtask

    task automatic test_store_plan();
        int lat, berr;
        logic [RW+2:0] post;
        logic [DW-1:0] want [4];
        want = '{16'h1111, 16'h2222, 16'h5555, 16'h7777};
        tb_rf[0] = 16'h1111; tb_rf[2] = 16'h2222; tb_rf[5] = 16'h5555; tb_rf[7] = 16'h7777;
        drive_op(1'b1, 8'b1010_0101, 16'h0040, 0, 3'd6, 1'b0, lat, berr, post);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (tb_mem[16'h0040 + 16'(i)] !== want[i]) begin
                n_fail++;
                $display("FAIL store_plan_mem[%0d]: got %h want %h", i, tb_mem[16'h0040 + 16'(i)], want[i]);
            end
        end
        n_tests++;
        if (q_diff() != -1) begin
            n_fail++; $display("FAIL store_plan_xfers: got %0d transfers, want %0d, first diff %0d", obs_q.size(), exp_q.size(), q_diff());
        end
        n_tests++;
        if (lat != exp_lat || berr != 0) begin
            n_fail++; $display("FAIL store_plan_latency: got %0d busy_err %0d, want %0d", lat, berr, exp_lat);
        end
        n_tests++;
        if (post !== {2'b00, 4'd4}) begin
            n_fail++; $display("FAIL store_plan_post: got done/busy/count %b, want 00_0100", post);
        end
    endtask

    task automatic test_load_wrap();
        int lat, berr;
        logic [RW+2:0] post;
        drive_op(1'b0, 8'hFF, 16'hFFFE, 0, 3'd3, 1'b0, lat, berr, post);
        n_tests++;
        if (obs_q.size() != 8 || obs_q[1][DW +: AW] !== 16'hFFFF || obs_q[2][DW +: AW] !== 16'h0000
            || obs_q[7][DW +: AW] !== 16'h0005) begin
            n_fail++; $display("FAIL load_wrap_addr: got %0d transfers, want FFFE..0005", obs_q.size());
        end
        n_tests++;
        if (q_diff() != -1 || rf_diff() != -1) begin
            n_fail++; $display("FAIL load_wrap_data: xfer diff %0d reg diff %0d, want -1/-1", q_diff(), rf_diff());
        end
        n_tests++;
        if (post[RW:0] !== 4'd8 || lat != exp_lat) begin
            n_fail++; $display("FAIL load_wrap_count: got count %0d lat %0d, want 8 lat %0d", post[RW:0], lat, exp_lat);
        end
    endtask

    task automatic test_empty_mask();
        int lat, berr;
        logic [RW+2:0] post;
        drive_op(1'b1, 8'h00, 16'h1234, 0, 3'd5, 1'b0, lat, berr, post);
        n_tests++;
        if (lat != exp_lat || req_cycles != 0) begin
            n_fail++; $display("FAIL empty_mask: got lat %0d requests %0d, want lat %0d requests 0", lat, req_cycles, exp_lat);
        end
        n_tests++;
        if (post !== 6'b00_0000 || wb_diff() != -1) begin
            n_fail++; $display("FAIL empty_mask_post: got %b wb diff %0d, want 000000 / -1", post, wb_diff());
        end
    endtask

    task automatic test_load_wait();
        int lat, berr;
        logic [RW+2:0] post;
        drive_op(1'b0, 8'b0110_1001, 16'h0200, 3, 3'd0, 1'b0, lat, berr, post);
        n_tests++;
        if (stab_err != 0 || dir_err != 0) begin
            n_fail++; $display("FAIL load_wait_stable: got stab_err %0d dir_err %0d, want 0/0", stab_err, dir_err);
        end
        n_tests++;
        if (q_diff() != -1 || wb_diff() != -1 || rf_diff() != -1) begin
            n_fail++; $display("FAIL load_wait_writes: xfer %0d wb %0d reg %0d, want -1", q_diff(), wb_diff(), rf_diff());
        end
        n_tests++;
        if (lat != exp_lat || post[RW:0] !== 4'd4) begin
            n_fail++; $display("FAIL load_wait_latency: got lat %0d count %0d, want %0d / 4", lat, post[RW:0], exp_lat);
        end
    endtask

    task automatic test_reset_mid();
        int lat, berr;
        logic [RW+2:0] post;
        cur_store = 1'b1; ack_delay = 0;
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; base_addr = 16'h0100; reg_mask = 8'h0F;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, rf_wen, mem_ren, mem_wen, count, rf_radd, rf_wadd, rf_wdata, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b wen=%b count=%0d addr=%h wdata=%h, want all 0", busy, mem_wen, count, mem_addr, mem_wdata);
        end
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        drive_op(1'b1, 8'h0F, 16'h0100, 0, 3'd1, 1'b0, lat, berr, post);
        n_tests++;
        if (q_diff() != -1 || lat != exp_lat || post !== {2'b00, 4'd4}) begin
            n_fail++; $display("FAIL reset_rerun: xfer diff %0d lat %0d post %b, want -1 lat %0d post 000100", q_diff(), lat, post, exp_lat);
        end
    endtask

    task automatic test_start_while_busy();
        int lat, berr;
        logic [RW+2:0] post;
        drive_op(1'b1, 8'h3C, 16'h0300, 2, 3'd4, 1'b1, lat, berr, post);
        n_tests++;
        if (q_diff() != -1 || lat != exp_lat || berr != 0) begin
            n_fail++; $display("FAIL busy_start: xfer diff %0d lat %0d berr %0d, want -1 lat %0d 0", q_diff(), lat, berr, exp_lat);
        end
        n_tests++;
        if (post !== {2'b00, 4'd4}) begin
            n_fail++; $display("FAIL busy_start_post: got %b, want 000100", post);
        end
    endtask

`ifdef LSM_WRITEBACK_EN
    task automatic test_writeback();
        int lat, berr;
        logic [RW+2:0] post;
        drive_op(1'b0, 8'h06, 16'h0010, 0, 3'd2, 1'b0, lat, berr, post);
        n_tests++;
        if (tb_rf[2] !== 16'h0012 || wb_q.size() != 1 || wb_q[0] !== {3'd2, 16'h0012}) begin
            n_fail++; $display("FAIL writeback: got r2=%h wb entries %0d, want r2=0012 one entry", tb_rf[2], wb_q.size());
        end
        n_tests++;
        if (tb_rf[1] !== exp_rf[1] || lat != 3) begin
            n_fail++; $display("FAIL writeback_load: got r1=%h lat %0d, want r1=%h lat 3", tb_rf[1], lat, exp_rf[1]);
        end
    endtask
`endif

    task automatic test_random();
        int lat, berr, dly;
        bit st, pb;
        logic [7:0] mask;
        logic [AW-1:0] base;
        logic [RW+2:0] post;
        for (int n = 0; n < 30; n++) begin
            st   = 1'($urandom);
            mask = 8'($urandom_range(0, 255));
            base = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
            dly  = $urandom_range(0, 2);
            pb   = (dly > 0) && ($urandom_range(0, 1) == 1);
            drive_op(st, mask, base, dly, 3'($urandom), pb, lat, berr, post);
            n_tests++;
            if (q_diff() != -1 || wb_diff() != -1 || rf_diff() != -1) begin
                n_fail++; $display("FAIL random[%0d] data: xfer %0d wb %0d reg %0d, want -1", n, q_diff(), wb_diff(), rf_diff());
            end
            n_tests++;
            if (lat != exp_lat || berr != 0 || stab_err != 0 || dir_err != 0) begin
                n_fail++; $display("FAIL random[%0d] timing: lat %0d berr %0d stab %0d dir %0d, want lat %0d", n, lat, berr, stab_err, dir_err, exp_lat);
            end
            n_tests++;
            if (post !== {2'b00, 4'(exp_cnt)}) begin
                n_fail++; $display("FAIL random[%0d] post: got %b, want count %0d idle", n, post, exp_cnt);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        for (int i = 0; i < NR; i++) tb_rf[i] = DW'($urandom);
        repeat (3) @(negedge clk);
        test_reset();
        #2 reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_store_plan();
        test_load_wrap();
        test_empty_mask();
        test_load_wait();
        test_reset_mid();
        test_start_while_busy();
`ifdef LSM_WRITEBACK_EN
        test_writeback();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
